// File: rtl/mem_access_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous memory (1-cycle read latency).
// The load/store port has fixed priority; a saturating starvation counter forces an IF grant.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | no access in flight; arbitrate between IF and LS
// ACCESS    | memory strobed for the granted owner; requests ignored
// READ_WAIT | memory drives read data; return it to owner and re-arbitrate
module mem_access_arbiter #(
  parameter int DATA_SIZE    = 32,
  parameter int MEM_SIZE     = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 sys_clk,
  input  logic                 resetn,
  input  logic                 if_req,
  input  logic [MEM_SIZE-1:0]  if_addr,
  output logic                 if_gnt,
  output logic                 if_rvalid,
  output logic [DATA_SIZE-1:0] if_rdata,
  input  logic                 ls_req,
  input  logic                 ls_we,
  input  logic [MEM_SIZE-1:0]  ls_addr,
  input  logic [DATA_SIZE-1:0] ls_wdata,
  output logic                 ls_gnt,
  output logic                 ls_rvalid,
  output logic [DATA_SIZE-1:0] ls_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [MEM_SIZE-1:0]  mem_addr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  input  logic [DATA_SIZE-1:0] mem_rdata,
  output logic                 busy
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ACCESS, READ_WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_LS} owner_t;

  state_t        r_state;
  state_t        w_next_state;
  owner_t        r_owner;
  logic [CW-1:0] r_starve_cnt;
  logic          w_arb;
  logic          w_starved;
  logic          w_grant_if;
  logic          w_grant_ls;

  always_comb begin
    w_arb        = (r_state == IDLE) || (r_state == READ_WAIT);
    w_starved    = if_req && (r_starve_cnt == LIMIT_C);
    w_grant_if   = w_arb && if_req && (w_starved || !ls_req);
    w_grant_ls   = w_arb && ls_req && !w_starved;
    w_next_state = r_state;
    case (r_state)
      IDLE:      if (w_grant_if || w_grant_ls) w_next_state = ACCESS;
      // mem_we is high in ACCESS exactly when the current access is a write
      ACCESS:    w_next_state = mem_we ? IDLE : READ_WAIT;
      READ_WAIT: w_next_state = (w_grant_if || w_grant_ls) ? ACCESS : IDLE;
      default:   w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_owner      <= OWN_IF;
      r_starve_cnt <= '0;
      busy         <= 1'b0;
      if_gnt       <= 1'b0;
      ls_gnt       <= 1'b0;
      if_rvalid    <= 1'b0;
      ls_rvalid    <= 1'b0;
      if_rdata     <= '0;
      ls_rdata     <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      r_state <= w_next_state;
      busy    <= (w_next_state != IDLE);
      if_gnt  <= w_grant_if;
      ls_gnt  <= w_grant_ls;
      mem_en  <= w_grant_if || w_grant_ls;
      mem_we  <= w_grant_ls && ls_we;

      if (w_grant_if) begin
        r_owner  <= OWN_IF;
        mem_addr <= if_addr;
      end else if (w_grant_ls) begin
        r_owner   <= OWN_LS;
        mem_addr  <= ls_addr;
        mem_wdata <= ls_wdata;
      end

      // return uses the owner of the access now finishing, not any new winner
      if_rvalid <= (r_state == READ_WAIT) && (r_owner == OWN_IF);
      ls_rvalid <= (r_state == READ_WAIT) && (r_owner == OWN_LS);
      if ((r_state == READ_WAIT) && (r_owner == OWN_IF)) if_rdata <= mem_rdata;
      if ((r_state == READ_WAIT) && (r_owner == OWN_LS)) ls_rdata <= mem_rdata;

      if (!if_req || w_grant_if) begin
        r_starve_cnt <= '0;
      end else if (w_grant_ls && (r_starve_cnt != LIMIT_C)) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Shares one synchronous single-port memory (1-cycle read latency) between two requesters:
  - the CPU instruction-fetch port (IF), which only reads;
  - the load/store port (LS), which reads and writes.
- Sits between the pipelined core's asynchronous fetch/LS interfaces and program/data memory, on the sys_clk domain.
- LS has fixed priority; a starvation counter guarantees IF forward progress.

Parameters:
- DATA_SIZE, 32, data word width.
- MEM_SIZE, 8, memory address width (2^MEM_SIZE words).
- STARVE_LIMIT, 4, consecutive LS grants allowed while IF waits; must be ≥1.

Ports:
- sys_clk  in  1  clock; all state changes on rising edge.
- resetn  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  MEM_SIZE  fetch address.
- if_gnt  out  1  one-cycle grant pulse.
- if_rvalid  out  1  one-cycle read-data-valid pulse.
- if_rdata  out  DATA_SIZE  fetch data; valid while if_rvalid.
- ls_req  in  1  load/store request; held with ls_we/ls_addr/ls_wdata until ls_gnt.
- ls_we  in  1  1 = write, 0 = read.
- ls_addr  in  MEM_SIZE  LS address.
- ls_wdata  in  DATA_SIZE  store data.
- ls_gnt  out  1  one-cycle grant pulse.
- ls_rvalid  out  1  one-cycle load-data-valid pulse (reads only).
- ls_rdata  out  DATA_SIZE  load data; valid while ls_rvalid.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  MEM_SIZE  memory address.
- mem_wdata  out  DATA_SIZE  memory write data.
- mem_rdata  in  DATA_SIZE  memory read data, valid the cycle after mem_en with mem_we=0.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- One clock (sys_clk); asynchronous active-low reset (resetn). All outputs are registered.
- Reset values, effective immediately on resetn=0:
  - state = IDLE.
  - All gnt, rvalid, mem_en, mem_we and busy outputs = 0.
  - mem_addr, mem_wdata, if_rdata, ls_rdata = 0.
  - owner = IF; starve_cnt = 0.
- FSM states: IDLE, ACCESS, READ_WAIT.
- Arbitration happens in IDLE and READ_WAIT. Winner selection, in order:
  - if if_req && starve_cnt == STARVE_LIMIT → IF;
  - else if ls_req → LS;
  - else if if_req → IF;
  - else no grant.
- Winner found at edge E0:
  - next state = ACCESS;
  - owner is registered;
  - mem_en=1, mem_we=(LS && ls_we), and mem_addr/mem_wdata are loaded from the winner;
  - winner's gnt=1, all for exactly the cycle after E0.
- ACCESS, read: next state = READ_WAIT. Memory drives mem_rdata during READ_WAIT.
- READ_WAIT: at the exiting edge E2:
  - owner's rdata <= mem_rdata and owner's rvalid=1 for one cycle;
  - the non-owner's rdata holds its value.
  - A new grant may be issued at the same edge, so back-to-back reads run one access per 2 cycles.
- ACCESS, write: next state = IDLE. No rvalid is produced.
- Read latency: rvalid is asserted two cycles after the gnt cycle.
- Starvation counter:
  - increments (saturating at STARVE_LIMIT) on each LS grant while if_req=1;
  - clears on an IF grant, or in any cycle with if_req=0.
- Requests in ACCESS are ignored: the owner's req is still high during its gnt cycle and must not be re-granted.
- A requester deasserting req before gnt withdraws the request; this is legal.
- mem_en/mem_we are high only in ACCESS.
- mem_addr/mem_wdata hold their last values otherwise.
- Reset asserted mid-operation (any state):
  - all outputs clear asynchronously;
  - an in-flight read is dropped, and no rvalid is issued after resetn rises;
  - the first grant after reset needs one full clock edge with resetn=1.

Test Plan:
1. Reset: resetn=0 with if_req=ls_req=1 → all outputs 0 and busy=0. Release → first gnt appears in the cycle after the first rising edge.
2. Single IF read: memory[0x10]=0xDEADBEEF, if_req with if_addr=0x10 → if_gnt plus mem_en with mem_addr=0x10 one cycle later; if_rvalid=1 with if_rdata=0xDEADBEEF two cycles after if_gnt; ls_rvalid stays 0.
3. Simultaneous reads: IF@0x01 and LS@0x02 requested together → ls_gnt first; if_gnt in the cycle ls_rvalid rises; both return correct data.
4. Starvation: STARVE_LIMIT=4, ls_req held high continuously (reads), if_req held → exactly 4 ls_gnt, then if_gnt, then LS resumes.
5. Write then read: LS write 0x12345678@0x20 → one cycle of mem_en=mem_we=1 and no ls_rvalid. Then IF read @0x20 → if_rdata=0x12345678.
6. Reset mid-read: resetn=0 during READ_WAIT → busy/gnt/mem_en clear without a clock. After release: no rvalid, and no grant until a new req.
